// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding IMEM request at a time, RV32I field
// split and immediate generation, and a valid/ready hand-off to the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] pc,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  regNum0,
    output logic [4:0]  regNum1,
    output logic [4:0]  regDest,
    output logic [31:0] imm,
    output logic        illegal
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        dec_valid_q, dec_valid_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] imm_q;
    logic        illegal_q;
    logic        load;

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        logic [31:0] r;
        r = 32'd0;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                r = {{20{ins[31]}}, ins[31:20]};
            7'b0100011:
                r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            7'b1100011:
                r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                r = {ins[31:12], 12'd0};
            7'b1101111:
                r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:
                r = 32'd0;
        endcase
        return r;
    endfunction

    // FENCE and SYSTEM are part of the base set but carry no immediate here.
    function automatic logic is_illegal(input logic [6:0] op);
        logic r;
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
            7'b1110011: r = 1'b0;
            default:    r = 1'b1;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        fetch_pc_d  = fetch_pc_q;
        dec_valid_d = dec_valid_q;
        load        = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                    // The old-address request was already accepted.
                    if (redirect_valid) kill_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        load        = 1'b1;
                        dec_valid_d = 1'b1;
                        fetch_pc_d  = fetch_pc_q + 32'd4;
                        state_d     = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || dec_ready) begin
                    dec_valid_d = 1'b0;
                    state_d     = ST_REQ;
                end
            end
            default: begin
                state_d     = ST_REQ;
                kill_d      = 1'b0;
                dec_valid_d = 1'b0;
            end
        endcase
        if (redirect_valid) fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            kill_q      <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            dec_valid_q <= 1'b0;
            pc_q        <= 32'd0;
            instr_q     <= 32'd0;
            imm_q       <= 32'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            fetch_pc_q  <= fetch_pc_d;
            dec_valid_q <= dec_valid_d;
            if (load) begin
                pc_q      <= fetch_pc_q;
                instr_q   <= imem_rdata;
                imm_q     <= imm_of(imem_rdata);
                illegal_q <= is_illegal(imem_rdata[6:0]);
            end
        end
    end

    // Qualified by rst_n so the request is also low while reset is held.
    assign imem_req  = (state_q == ST_REQ) && rst_n;
    assign imem_addr = imem_req ? {fetch_pc_q[31:2], 2'b00} : 32'd0;

    assign dec_valid = dec_valid_q;
    assign pc        = pc_q;
    assign opcode    = instr_q[6:0];
    assign func3     = instr_q[14:12];
    assign func7     = instr_q[31:25];
    assign regNum0   = instr_q[19:15];
    assign regNum1   = instr_q[24:20];
    assign regDest   = instr_q[11:7];
    assign imm       = imm_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table of instruction formats plus
// hand-written stall, redirect and reset sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  regNum0;
    logic [4:0]  regNum1;
    logic [4:0]  regDest;
    logic [31:0] imm;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .pc(pc),
        .opcode(opcode), .func3(func3), .func7(func7),
        .regNum0(regNum0), .regNum1(regNum1), .regDest(regDest),
        .imm(imm), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [24:0] fields;   // {func7, func3, regNum0, regNum1, regDest}
        logic [31:0] imm;
        logic        illegal;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("imem_req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // Request granted at once, response one cycle later, instruction presented.
    task automatic fetch_present(input logic [31:0] ins, input logic [31:0] addr);
        wait_req();
        chk("req_addr", imem_addr, addr);
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = ins;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        chk("dec_valid_latency", {31'd0, dec_valid}, 32'd1);
        chk("pc", pc, addr);
    endtask

    task automatic handshake();
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk("dec_valid_after_hs", {31'd0, dec_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'hFE208CE3, 7'h63, {7'h7F, 3'd0, 5'd1,  5'd2,  5'h19}, 32'hFFFF_FFF8, 1'b0}; // beq -8
        vecs[1] = '{32'h00512623, 7'h23, {7'h00, 3'd2, 5'd2,  5'd5,  5'h0C}, 32'h0000_000C, 1'b0}; // sw 12
        vecs[2] = '{32'h123451B7, 7'h37, {7'h09, 3'd5, 5'd8,  5'd3,  5'h03}, 32'h1234_5000, 1'b0}; // lui
        vecs[3] = '{32'hFFDFF0EF, 7'h6F, {7'h7F, 3'd7, 5'h1F, 5'h1D, 5'h01}, 32'hFFFF_FFFC, 1'b0}; // jal -4
        vecs[4] = '{32'h4032D213, 7'h13, {7'h20, 3'd5, 5'd5,  5'd3,  5'h04}, 32'h0000_0403, 1'b0}; // srai 3
        vecs[5] = '{32'h8000007F, 7'h7F, {7'h40, 3'd0, 5'd0,  5'd0,  5'h00}, 32'h0000_0000, 1'b1}; // illegal
        vecs[6] = '{32'h002081B3, 7'h33, {7'h00, 3'd0, 5'd1,  5'd2,  5'h03}, 32'h0000_0000, 1'b0}; // add
        vecs[7] = '{32'hFFF00093, 7'h13, {7'h7F, 3'd0, 5'd0,  5'h1F, 5'h01}, 32'hFFFF_FFFF, 1'b0}; // addi -1
        vecs[8] = '{32'hFFFFF297, 7'h17, {7'h7F, 3'd7, 5'h1F, 5'h1F, 5'h05}, 32'hFFFF_F000, 1'b0}; // auipc

        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; dec_ready = 1'b0;
        step(); step();
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_imm", imm, 32'd0);
        rst_n = 1'b1;

        // addi x1,x0,5 at RESET_PC, then a five-cycle decoder stall
        fetch_present(32'h00500093, 32'h100);
        chk("addi_opcode", {25'd0, opcode}, 32'h13);
        chk("addi_rd", {27'd0, regDest}, 32'd1);
        chk("addi_rs1", {27'd0, regNum0}, 32'd0);
        chk("addi_imm", imm, 32'd5);
        $display("txn addi pc=0x%08h imm=0x%08h", pc, imm);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_valid", {31'd0, dec_valid}, 32'd1);
            chk("stall_no_req", {31'd0, imem_req}, 32'd0);
            chk("stall_imm", imm, 32'd5);
            chk("stall_pc", pc, 32'h100);
        end
        handshake();
        chk("next_req", {31'd0, imem_req}, 32'd1);
        chk("next_addr", imem_addr, 32'h104);

        for (int i = 0; i < 9; i++) begin
            fetch_present(vecs[i].instr, 32'h104 + 32'(4 * i));
            chk("vec_opcode", {25'd0, opcode}, {25'd0, vecs[i].opcode});
            chk("vec_fields", {7'd0, func7, func3, regNum0, regNum1, regDest}, {7'd0, vecs[i].fields});
            chk("vec_imm", imm, vecs[i].imm);
            chk("vec_illegal", {31'd0, illegal}, {31'd0, vecs[i].illegal});
            $display("txn vec%0d instr=0x%08h pc=0x%08h imm=0x%08h illegal=%0b",
                     i, vecs[i].instr, pc, imm, illegal);
            handshake();
        end
        chk("after_vec_addr", imem_addr, 32'h128);

        // Redirect while waiting; the stale response must vanish
        wait_req();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        imem_rvalid = 1'b0; imem_rdata = 32'd0;
        chk("wait_redir_no_valid", {31'd0, dec_valid}, 32'd0);
        chk("wait_redir_req", {31'd0, imem_req}, 32'd1);
        chk("wait_redir_addr", imem_addr, 32'h200);
        fetch_present(32'h123451B7, 32'h200);
        $display("txn redirect_wait pc=0x%08h", pc);
        handshake();

        // Redirect in the same cycle as the grant
        wait_req();
        chk("gnt_redir_old_addr", imem_addr, 32'h204);
        imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        imem_gnt = 1'b0; redirect_valid = 1'b0;
        chk("gnt_redir_waiting", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        imem_rvalid = 1'b0; imem_rdata = 32'd0;
        chk("gnt_redir_no_valid", {31'd0, dec_valid}, 32'd0);
        chk("gnt_redir_addr", imem_addr, 32'h300);
        fetch_present(32'h002081B3, 32'h300);
        $display("txn redirect_gnt pc=0x%08h", pc);
        handshake();

        // Redirect while holding, with a simultaneous dec_ready
        fetch_present(32'h00512623, 32'h304);
        redirect_valid = 1'b1; redirect_pc = 32'h400; dec_ready = 1'b1;
        step();
        redirect_valid = 1'b0; dec_ready = 1'b0;
        chk("hold_redir_valid", {31'd0, dec_valid}, 32'd0);
        chk("hold_redir_addr", imem_addr, 32'h400);
        $display("txn redirect_hold addr=0x%08h", imem_addr);

        // Reset while holding an instruction
        fetch_present(32'hFFF00093, 32'h400);
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", {31'd0, dec_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_hold_req", {31'd0, imem_req}, 32'd1);
        chk("rst_hold_addr", imem_addr, 32'h100);
        $display("txn reset_hold addr=0x%08h", imem_addr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end stage that feeds the instruction decoder.
- Fetches 32-bit RV32I instructions from the instruction memory over a request/grant/response handshake.
- Splits each instruction into opcode, func3, func7, register numbers and a sign-extended immediate, then presents them to the decoder under a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and discards any wrong-path fetch that is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address; always word-aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  PC redirect strobe.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- dec_valid  out  1  decoded fields valid.
- dec_ready  in  1  decoder accepts fields.
- pc  out  32  address of the presented instruction.
- opcode  out  7  instr[6:0].
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].
- regNum0  out  5  instr[19:15].
- regNum1  out  5  instr[24:20].
- regDest  out  5  instr[11:7].
- imm  out  32  sign-extended immediate.
- illegal  out  1  opcode not in RV32I base set.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC, state = REQ, kill = 0.
  - All outputs are 0, including dec_valid and imem_req.
- State REQ:
  - imem_req = 1, imem_addr = fetch_pc.
  - imem_gnt = 1 moves to WAIT.
- State WAIT:
  - imem_req = 0.
  - imem_rvalid = 1 with kill = 1: drop the data, clear kill, go to REQ.
  - imem_rvalid = 1 with kill = 0: register the fields, set dec_valid = 1 next cycle, pc = fetch_pc, fetch_pc += 4 (mod 2^32), go to HOLD.
- State HOLD:
  - dec_valid = 1; all field outputs are stable until handshake.
  - dec_valid & dec_ready moves to REQ; dec_valid = 0 the following cycle.
- Latency:
  - Best case: gnt in cycle 0, rvalid in cycle 1, dec_valid in cycle 2.
  - One instruction is outstanding at most; no overlap of request and presentation.
- Field decode, registered together with dec_valid:
  - I-type (0010011, 0000011, 1100111): imm = sext(instr[31:20]); imm[10] = instr[30] for srai/srli selection.
  - S-type (0100011): imm = sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type (0110111, 0010111): imm = {instr[31:12], 12'b0}.
  - J-type (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-type (0110011): imm = 0.
  - Any other opcode: imm = 0 and illegal = 1. The instruction is still presented; the fetch does not stall.
- Redirect (redirect_valid = 1), highest priority in every state:
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - dec_valid is cleared next cycle; a same-cycle dec_ready is ignored.
  - In REQ without gnt: the next request goes to the new address.
  - In REQ with gnt the same cycle: the old-address request was accepted, so go to WAIT with kill = 1.
  - In WAIT without rvalid: set kill = 1 and stay in WAIT.
  - In WAIT with rvalid the same cycle: drop the data and go to REQ.
  - In HOLD: drop the presented instruction and go to REQ.
- Back-to-back redirects: the last one wins; kill stays set until exactly one response is consumed.
- Reset mid-transaction: state returns to REQ and kill = 0. A response arriving after reset release is discarded, because the memory is reset from the same rst_n.

Test Plan:
- Reset release with RESET_PC = 0x100, memory returns 0x00500093 (addi x1,x0,5) with gnt at cycle 0 and rvalid at cycle 1 → dec_valid at cycle 2, pc = 0x100, opcode = 0x13, regDest = 1, regNum0 = 0, imm = 5; next imem_addr = 0x104.
- dec_ready held low for 5 cycles → all fields stable, no new imem_req. Assert dec_ready → one handshake, then imem_req with addr 0x104.
- Immediate formats:
  - beq offset -8 → imm = 0xFFFFFFF8.
  - sw offset 12 → imm = 12.
  - lui 0x12345 → imm = 0x12345000.
  - jal offset -4 → imm = 0xFFFFFFFC.
  - srai shamt 3 → imm = 0x403.
- Redirect to 0x203 while in WAIT; the stale rvalid returns 0xDEADBEEF → no dec_valid, next imem_addr = 0x200.
- Redirect in the same cycle as gnt → the next response is discarded, then a fetch from the target occurs.
- Opcode 0x7F → illegal = 1, imm = 0, dec_valid asserted.
- rst_n asserted while in HOLD → dec_valid drops immediately and the next fetch is from RESET_PC.
